// File: rtl/bt_seq_mac.sv
// Trit-serial balanced-ternary ADD/SUB/MUL/MAC with 2N-trit result and accumulator.
// Latency 1 cycle (ADD/SUB) or N_TRITS+1 (MUL/MAC); result held in DONE until out_ready, no accept outside IDLE.
module bt_seq_mac #(
  parameter int N_TRITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic                   acc_clr,
  input  logic [2*N_TRITS-1:0]   a,
  input  logic [2*N_TRITS-1:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*N_TRITS-1:0]   result,
  output logic                   err,
  output logic                   ovf
);

  localparam int NW = 2 * N_TRITS;
  localparam int RW = 4 * N_TRITS;
  localparam int CW = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
  localparam logic [RW-1:0] ZERO_R   = {(2 * N_TRITS){2'b11}};
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TRITS - 1);
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  function automatic logic signed [2:0] trit_val(input logic [1:0] t);
    case (t)
      2'b10:   return 3'sd1;
      2'b01:   return -3'sd1;
      default: return 3'sd0;
    endcase
  endfunction

  function automatic logic [1:0] trit_enc(input logic signed [2:0] v);
    if (v == 3'sd1) return 2'b10;
    if (v == -3'sd1) return 2'b01;
    return 2'b11;
  endfunction

  // Full adder on one trit position: returns {signed carry, encoded digit}.
  function automatic logic [4:0] trit_fa(input logic [1:0] x, input logic [1:0] y,
                                         input logic signed [2:0] cin);
    logic signed [2:0] s;
    s = trit_val(x) + trit_val(y) + cin;
    if (s > 3'sd1) return {3'sd1, trit_enc(s - 3'sd3)};
    if (s < -3'sd1) return {-3'sd1, trit_enc(s + 3'sd3)};
    return {3'sd0, trit_enc(s)};
  endfunction

  function automatic logic [RW-1:0] add_sum(input logic [RW-1:0] x, input logic [RW-1:0] y);
    logic [RW-1:0]     r;
    logic signed [2:0] c;
    logic [1:0]        d;
    c = 3'sd0;
    r = '0;
    for (int k = 0; k < 2 * N_TRITS; k++) begin
      {c, d} = trit_fa(x[2*k +: 2], y[2*k +: 2], c);
      r[2*k +: 2] = d;
    end
    return r;
  endfunction

  function automatic logic [1:0] add_carry(input logic [RW-1:0] x, input logic [RW-1:0] y);
    logic signed [2:0] c;
    logic [1:0]        d;
    c = 3'sd0;
    for (int k = 0; k < 2 * N_TRITS; k++) begin
      {c, d} = trit_fa(x[2*k +: 2], y[2*k +: 2], c);
    end
    return trit_enc(c);
  endfunction

  // Swapping the two bits negates a trit and leaves 0 (and invalid) untouched.
  function automatic logic [RW-1:0] neg_all(input logic [RW-1:0] x);
    logic [RW-1:0] r;
    for (int k = 0; k < 2 * N_TRITS; k++) r[2*k +: 2] = {x[2*k], x[2*k+1]};
    return r;
  endfunction

  function automatic logic has_invalid(input logic [NW-1:0] x);
    logic r;
    r = 1'b0;
    for (int k = 0; k < N_TRITS; k++) r = r | (x[2*k +: 2] == 2'b00);
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          acc_clr_q, acc_clr_d;
  logic          err_pend_q, err_pend_d;
  logic [RW-1:0] mcand_q, mcand_d;
  logic [NW-1:0] mplier_q, mplier_d;
  logic [RW-1:0] prod_q, prod_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] result_q, result_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;

  logic          in_err;
  logic [RW-1:0] a_ext, b_ext, addsub_sum, partial, prod_next, mac_base, mac_sum;
  logic [1:0]    mac_carry;

  always_comb begin
    in_err     = has_invalid(a) | has_invalid(b);
    a_ext      = {{N_TRITS{2'b11}}, a};
    b_ext      = {{N_TRITS{2'b11}}, b};
    addsub_sum = add_sum(a_ext, (op == OP_SUB) ? neg_all(b_ext) : b_ext);

    // mplier_q shifts right each step, so its low trit is b[i] on step i.
    case (mplier_q[1:0])
      2'b10:   partial = mcand_q;
      2'b01:   partial = neg_all(mcand_q);
      default: partial = ZERO_R;
    endcase
    prod_next = add_sum(prod_q, partial);
    mac_base  = acc_clr_q ? ZERO_R : acc_q;
    mac_sum   = add_sum(mac_base, prod_next);
    mac_carry = add_carry(mac_base, prod_next);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    acc_clr_d  = acc_clr_q;
    err_pend_d = err_pend_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    result_d   = result_q;
    err_d      = err_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d       = op;
          acc_clr_d  = acc_clr;
          err_pend_d = in_err;
          if (!op[1]) begin
            state_d  = S_DONE;
            result_d = in_err ? ZERO_R : addsub_sum;
            err_d    = in_err;
            ovf_d    = 1'b0;
          end else begin
            state_d  = S_CALC;
            cnt_d    = '0;
            prod_d   = ZERO_R;
            mcand_d  = a_ext;
            mplier_d = b;
          end
        end
      end
      S_CALC: begin
        prod_d   = prod_next;
        mcand_d  = {mcand_q[RW-3:0], 2'b11};
        mplier_d = {2'b11, mplier_q[NW-1:2]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          err_d   = err_pend_q;
          ovf_d   = 1'b0;
          if (err_pend_q) begin
            result_d = ZERO_R;
          end else if (op_q == OP_MAC) begin
            acc_d    = mac_sum;
            result_d = mac_sum;
            ovf_d    = (mac_carry != 2'b11);
          end else begin
            result_d = prod_next;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      acc_clr_q  <= 1'b0;
      err_pend_q <= 1'b0;
      mcand_q    <= ZERO_R;
      mplier_q   <= {N_TRITS{2'b11}};
      prod_q     <= ZERO_R;
      acc_q      <= ZERO_R;
      result_q   <= ZERO_R;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      acc_clr_q  <= acc_clr_d;
      err_pend_q <= err_pend_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bt_seq_mac.sv
// Directed bench for bt_seq_mac with N_TRITS=4; expected values are decimal and encoded to trits here.
module tb_bt_seq_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        acc_clr;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        err;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] ZERO16 = 16'hFFFF;

  bt_seq_mac #(.N_TRITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] enc8(input int v);
    logic [15:0] r;
    int x, m;
    x = v;
    for (int k = 0; k < 8; k++) begin
      m = ((x % 3) + 3) % 3;
      if (m == 0) begin r[2*k +: 2] = 2'b11; x = x / 3; end
      else if (m == 1) begin r[2*k +: 2] = 2'b10; x = (x - 1) / 3; end
      else begin r[2*k +: 2] = 2'b01; x = (x + 1) / 3; end
    end
    return r;
  endfunction

  function automatic logic [7:0] enc4(input int v);
    logic [15:0] r;
    r = enc8(v);
    return r[7:0];
  endfunction

  // Present one op at the current cycle, wait for out_valid (bounded), capture and consume.
  task automatic run_op(input logic [1:0] o, input logic clr, input logic [7:0] av,
                        input logic [7:0] bv, output int lat, output logic [15:0] res,
                        output logic e, output logic v);
    in_valid = 1'b1; op = o; acc_clr = clr; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; acc_clr = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result; e = err; v = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; acc_clr = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== ZERO16) begin errors++; $display("FAIL reset_result got %h want %h", result, ZERO16); end
    checks++; if (err !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got err=%b ovf=%b want 0 0", err, ovf); end
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat; logic [15:0] res; logic e, v;
    run_op(2'b00, 1'b0, enc4(13), enc4(13), lat, res, e, v);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
    checks++; if (res !== enc8(26)) begin errors++; $display("FAIL add_13_13 got %h want %h", res, enc8(26)); end
    checks++; if (e !== 1'b0 || v !== 1'b0) begin errors++; $display("FAIL add_flags got err=%b ovf=%b want 0 0", e, v); end
    run_op(2'b00, 1'b0, 8'b10101010, 8'b10101010, lat, res, e, v);
    checks++; if (res !== enc8(80)) begin errors++; $display("FAIL add_40_40_carry got %h want %h", res, enc8(80)); end
  endtask

  task automatic test_sub;
    int lat; logic [15:0] res; logic e, v;
    run_op(2'b01, 1'b0, enc4(-7), enc4(33), lat, res, e, v);
    checks++; if (res !== enc8(-40)) begin errors++; $display("FAIL sub_m7_33 got %h want %h", res, enc8(-40)); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL sub_latency got %0d want 1", lat); end
  endtask

  task automatic test_mac_clear;
    int lat; logic [15:0] res; logic e, v;
    run_op(2'b11, 1'b1, enc4(40), enc4(40), lat, res, e, v);
    checks++; if (res !== enc8(1600)) begin errors++; $display("FAIL mac_clr got %h want %h", res, enc8(1600)); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL mac_latency got %0d want 5", lat); end
  endtask

  task automatic test_mul;
    int lat; logic [15:0] res; logic e, v;
    run_op(2'b10, 1'b0, enc4(13), enc4(-13), lat, res, e, v);
    checks++; if (lat !== 5) begin errors++; $display("FAIL mul_latency got %0d want 5", lat); end
    checks++; if (res !== enc8(-169)) begin errors++; $display("FAIL mul_13_m13 got %h want %h", res, enc8(-169)); end
    checks++; if (e !== 1'b0 || v !== 1'b0) begin errors++; $display("FAIL mul_flags got err=%b ovf=%b want 0 0", e, v); end
    run_op(2'b10, 1'b0, enc4(-40), enc4(-40), lat, res, e, v);
    checks++; if (res !== enc8(1600)) begin errors++; $display("FAIL mul_m40_m40 got %h want %h", res, enc8(1600)); end
  endtask

  task automatic test_err;
    int lat; logic [15:0] res; logic e, v;
    logic [7:0] bad;
    bad = enc4(5);
    bad[5:4] = 2'b00;
    run_op(2'b10, 1'b0, bad, enc4(7), lat, res, e, v);
    checks++; if (lat !== 5) begin errors++; $display("FAIL err_latency got %0d want 5", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_flag got %b want 1", e); end
    checks++; if (res !== ZERO16 || v !== 1'b0) begin errors++; $display("FAIL err_result got %h ovf=%b want %h ovf=0", res, v, ZERO16); end
    run_op(2'b00, 1'b0, enc4(1), enc4(1), lat, res, e, v);
    checks++; if (e !== 1'b0 || res !== enc8(2)) begin errors++; $display("FAIL err_clears got err=%b res=%h want 0 %h", e, res, enc8(2)); end
  endtask

  task automatic test_mac_accum;
    int lat; logic [15:0] res; logic e, v;
    run_op(2'b11, 1'b0, enc4(40), enc4(40), lat, res, e, v);
    checks++; if (res !== enc8(3200) || v !== 1'b0) begin errors++; $display("FAIL mac_3200 got %h ovf=%b want %h ovf=0", res, v, enc8(3200)); end
    run_op(2'b11, 1'b0, enc4(40), enc4(40), lat, res, e, v);
    checks++; if (res !== enc8(-1761)) begin errors++; $display("FAIL mac_wrap got %h want %h", res, enc8(-1761)); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL mac_ovf got %b want 1", v); end
    run_op(2'b00, 1'b0, enc4(2), enc4(2), lat, res, e, v);
    checks++; if (v !== 1'b0 || res !== enc8(4)) begin errors++; $display("FAIL add_after_ovf got ovf=%b res=%h want 0 %h", v, res, enc8(4)); end
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    in_valid = 1'b1; op = 2'b00; a = enc4(1); b = enc4(1);
    @(posedge clk); #1;
    a = enc4(5); b = enc4(5);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== enc8(2)) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b res=%h want 1 0 %h", i, out_valid, in_ready, result, enc8(2));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    checks++; if (result !== enc8(2)) begin errors++; $display("FAIL bp_idle_hold got %h want %h", result, enc8(2)); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== enc8(10)) begin errors++; $display("FAIL bp_next got vld=%b res=%h want 1 %h", out_valid, result, enc8(10)); end
    @(posedge clk); #1;
    lat = 0;
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] res; logic e, v;
    logic seen;
    in_valid = 1'b1; op = 2'b11; acc_clr = 1'b0; a = enc4(40); b = enc4(40);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_state got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    checks++; if (result !== ZERO16) begin errors++; $display("FAIL mid_rst_result got %h want %h", result, ZERO16); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_no_result got %b want 0", seen); end
    run_op(2'b10, 1'b0, enc4(2), enc4(3), lat, res, e, v);
    checks++; if (res !== enc8(6) || lat !== 5) begin errors++; $display("FAIL mid_rst_mul got %h lat=%0d want %h lat=5", res, lat, enc8(6)); end
    run_op(2'b11, 1'b0, enc4(1), enc4(1), lat, res, e, v);
    checks++; if (res !== enc8(1)) begin errors++; $display("FAIL mid_rst_acc_zero got %h want %h", res, enc8(1)); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_mac_clear;
    test_mul;
    test_err;
    test_mac_accum;
    test_backpressure;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
